// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the register-file writeback arbiter.
//   Contents:
//     REG_ADDR_W / NUM_REGS / XLEN_DEFAULT - register-file geometry
//     STARVE_W                             - width of the LSU starvation counter
//     wb_pri_e                             - arbiter priority state
//     wb_req_t                             - one writeback request (valid, rd, data)
//     sat_inc()                            - saturating increment for the counter
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 32;
    localparam int XLEN_DEFAULT = 32;
    localparam int STARVE_W     = 4;

    typedef enum logic {
        ALU_PRI = 1'b0,
        LSU_PRI = 1'b1
    } wb_pri_e;

    typedef struct packed {
        logic                    valid;
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_req_t;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
//   Writeback bus between the two requesters (ALU, LSU) and the arbiter, plus
//   the arbiter's register-file write port.
//   Handshake: a request transfers in any cycle where valid && ready. The
//   requester holds valid, rd and data stable until it sees ready. ready is a
//   combinational function of both valids and the arbiter priority state and
//   never depends on ready; at most one ready is high in a cycle.
//   Modports:
//     master - requester side / testbench: drives *_valid, *_rd, *_data,
//              observes *_ready and rf_*.
//     slave  - arbiter side: the reverse.
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int XLEN = regfile_pkg::XLEN_DEFAULT
);
    logic                              alu_valid;
    logic [regfile_pkg::REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]                   alu_data;
    logic                              alu_ready;

    logic                              lsu_valid;
    logic [regfile_pkg::REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]                   lsu_data;
    logic                              lsu_ready;

    logic                              rf_we;
    logic [regfile_pkg::REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]                   rf_wdata;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready,
        input  rf_we, rf_rd, rf_wdata
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready,
        output rf_we, rf_rd, rf_wdata
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Tracks register-file destinations of loads that have issued but not yet
//   written back, and flags decode-stage sources that depend on them.
//   Ports:
//     clk, res      - clock, asynchronous active-low reset
//     set_valid_i   - a load issued this cycle
//     set_rd_i      - its destination (x0 is never tracked)
//     clr_valid_i   - the LSU writeback was granted this cycle
//     clr_rd_i      - destination of that writeback
//     chk_rs1_i/2_i - decode-stage source registers
//     hazard_o      - a non-zero source has an outstanding load
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  res,
    input  logic                  set_valid_i,
    input  logic [REG_ADDR_W-1:0] set_rd_i,
    input  logic                  clr_valid_i,
    input  logic [REG_ADDR_W-1:0] clr_rd_i,
    input  logic [REG_ADDR_W-1:0] chk_rs1_i,
    input  logic [REG_ADDR_W-1:0] chk_rs2_i,
    output logic                  hazard_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clear is applied first so that a new load to the same rd issued in the
    // same cycle as the previous load's writeback keeps the bit set.
    always_comb begin
        pending_d = pending_q;
        if (clr_valid_i) begin
            pending_d[clr_rd_i] = 1'b0;
        end
        if (set_valid_i && (set_rd_i != '0)) begin
            pending_d[set_rd_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign hazard_o = ((chk_rs1_i != '0) && pending_q[chk_rs1_i]) ||
                      ((chk_rs2_i != '0) && pending_q[chk_rs2_i]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port between the ALU and the LSU.
//   Fixed priority to the ALU, except that an LSU request blocked for
//   STARVE_MAX consecutive cycles wins the following cycle. The winning
//   request is written to the register file one cycle after its grant from
//   registered outputs; a grant to x0 is accepted but not written.
//
//   Optional feature (macro REGFILE_WB_SCOREBOARD_EN): a pending-load mask
//   that raises hazard for decode sources with an outstanding load. Without
//   the macro there is no mask, hazard is 0 and issue_ld_* / chk_* are unused.
//
//   Parameters:
//     XLEN       - data width of the register file
//     STARVE_MAX - blocked LSU cycles before it is forced ahead (1..15)
//   Ports:
//     clk, res                  - clock, asynchronous active-low reset
//     wb (slave modport)        - ALU/LSU request handshakes and rf_we/rf_rd/rf_wdata
//     issue_ld_valid/_rd        - load issue, sets a pending bit
//     chk_rs1, chk_rs2          - decode-stage sources to check
//     hazard                    - a source has an outstanding load
//     dbg_state, dbg_starve_cnt - current priority state and starvation count
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  res,
    regfile_wb_arbiter_if.slave   wb,
    input  logic                  issue_ld_valid,
    input  logic [REG_ADDR_W-1:0] issue_ld_rd,
    input  logic [REG_ADDR_W-1:0] chk_rs1,
    input  logic [REG_ADDR_W-1:0] chk_rs2,
    output logic                  hazard,
    output wb_pri_e               dbg_state,
    output logic [STARVE_W-1:0]   dbg_starve_cnt
);

    // Count value at which one more blocked cycle hands priority to the LSU.
    localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_MAX - 1);

    wb_pri_e               state_q,      state_d;
    logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic                  rf_we_q,      rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rd_q,      rf_rd_d;
    logic [XLEN-1:0]       rf_wdata_q,   rf_wdata_d;

    wb_req_t alu_req;
    wb_req_t lsu_req;
    wb_req_t win_req;
    logic    alu_gnt;
    logic    lsu_gnt;
    logic    any_gnt;
    logic    lsu_blocked;

    // Grant decode. Both grants are forced low while reset is asserted so no
    // requester sees a handshake complete during reset.
    always_comb begin
        alu_req.valid = wb.alu_valid;
        alu_req.rd    = wb.alu_rd;
        alu_req.data  = wb.alu_data;
        lsu_req.valid = wb.lsu_valid;
        lsu_req.rd    = wb.lsu_rd;
        lsu_req.data  = wb.lsu_data;

        alu_gnt = res && alu_req.valid && ((state_q == ALU_PRI) || !lsu_req.valid);
        lsu_gnt = res && lsu_req.valid && ((state_q == LSU_PRI) || !alu_req.valid);

        any_gnt     = alu_gnt || lsu_gnt;
        lsu_blocked = lsu_req.valid && !lsu_gnt;
        win_req     = alu_gnt ? alu_req : lsu_req;
    end

    // Next-state logic for priority, starvation count and the write port.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        rf_we_d      = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_wdata_d   = rf_wdata_q;

        if (lsu_blocked) begin
            starve_cnt_d = sat_inc(starve_cnt_q);
        end else begin
            starve_cnt_d = '0;
        end

        case (state_q)
            ALU_PRI: begin
                if (lsu_blocked && (starve_cnt_q == STARVE_LAST)) begin
                    state_d = LSU_PRI;
                end
            end
            LSU_PRI: begin
                if (lsu_gnt || !lsu_req.valid) begin
                    state_d = ALU_PRI;
                end
            end
            default: state_d = ALU_PRI;
        endcase

        // rd/data follow every grant; the enable alone suppresses x0 writes.
        if (any_gnt) begin
            rf_we_d    = win_req.valid && (win_req.rd != '0);
            rf_rd_d    = win_req.rd;
            rf_wdata_d = win_req.data;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= ALU_PRI;
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign wb.alu_ready = alu_gnt;
    assign wb.lsu_ready = lsu_gnt;
    assign wb.rf_we     = rf_we_q;
    assign wb.rf_rd     = rf_rd_q;
    assign wb.rf_wdata  = rf_wdata_q;

    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    regfile_scoreboard u_scoreboard (
        .clk         (clk),
        .res         (res),
        .set_valid_i (issue_ld_valid),
        .set_rd_i    (issue_ld_rd),
        .clr_valid_i (lsu_gnt),
        .clr_rd_i    (wb.lsu_rd),
        .chk_rs1_i   (chk_rs1),
        .chk_rs2_i   (chk_rs2),
        .hazard_o    (hazard)
    );
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_ld_valid, issue_ld_rd, chk_rs1, chk_rs2};
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 4;
    localparam int W          = 1 + 5 + XLEN;
`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(XLEN)) wb();

    logic        issue_ld_valid;
    logic [4:0]  issue_ld_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        hazard;
    wb_pri_e     dbg_state;
    logic [3:0]  dbg_starve_cnt;

    regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk            (clk),
        .res            (res),
        .wb             (wb),
        .issue_ld_valid (issue_ld_valid),
        .issue_ld_rd    (issue_ld_rd),
        .chk_rs1        (chk_rs1),
        .chk_rs2        (chk_rs2),
        .hazard         (hazard),
        .dbg_state      (dbg_state),
        .dbg_starve_cnt (dbg_starve_cnt)
    );

    // ---------------- scoreboard state ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [W-1:0]   exp_q[$];
    bit             chk_en    = 1'b0;
    int             cyc       = 0;
    int             lsu_gnt_cyc[$];
    bit             pend[32];
    int             lsu_wait  = 0;
    bit             rand_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each cycle: the LSU wins if the ALU is idle or the LSU has already
    // waited STARVE_MAX cycles in a row; otherwise the ALU wins. The winner's
    // write (none for x0, none without a grant) is expected one cycle later.
    always @(negedge clk) begin
        if (chk_en) begin
            bit a_win;
            bit l_win;
            bit exp_h;
            l_win = wb.lsu_valid && (!wb.alu_valid || (lsu_wait >= STARVE_MAX));
            a_win = wb.alu_valid && !l_win;
            check("alu_ready", 64'(wb.alu_ready), 64'(a_win));
            check("lsu_ready", 64'(wb.lsu_ready), 64'(l_win));
            exp_h = ((chk_rs1 != 0) && pend[chk_rs1]) || ((chk_rs2 != 0) && pend[chk_rs2]);
            check("hazard", 64'(hazard), 64'(exp_h));

            if (a_win)
                exp_q.push_back({wb.alu_rd != 0, wb.alu_rd, wb.alu_data});
            else if (l_win)
                exp_q.push_back({wb.lsu_rd != 0, wb.lsu_rd, wb.lsu_data});
            else
                exp_q.push_back('0);

            if (wb.lsu_valid && !l_win) lsu_wait = (lsu_wait < 15) ? lsu_wait + 1 : 15;
            else                        lsu_wait = 0;

            if (l_win) begin
                lsu_gnt_cyc.push_back(cyc);
                pend[wb.lsu_rd] = 1'b0;
            end
            if (SB_EN && issue_ld_valid && (issue_ld_rd != 0)) pend[issue_ld_rd] = 1'b1;
            cyc++;
        end
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [W-1:0] e;
        #2;
        if (chk_en && (exp_q.size() > 0)) begin
            e = exp_q.pop_front();
            check("rf_we", 64'(wb.rf_we), 64'(e[W-1]));
            if (e[W-1]) check("rf_write", 64'({wb.rf_rd, wb.rf_wdata}), 64'(e[W-2:0]));
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end at posedge + 1.
    task automatic alu_send(input logic [4:0] rd, input logic [31:0] data);
        int  waited = 0;
        bit  done   = 0;
        wb.alu_valid = 1'b1; wb.alu_rd = rd; wb.alu_data = data;
        while (!done) begin
            @(negedge clk);
            if (wb.alu_ready) done = 1;
            else if (++waited > 50) begin
                n_checks++; n_fail++;
                $display("FAIL alu_timeout: got no ready expected ready within 50 cycles");
                done = 1;
            end
            @(posedge clk); #1;
        end
        wb.alu_valid = 1'b0;
    endtask

    task automatic lsu_send(input logic [4:0] rd, input logic [31:0] data);
        int  waited = 0;
        bit  done   = 0;
        wb.lsu_valid = 1'b1; wb.lsu_rd = rd; wb.lsu_data = data;
        while (!done) begin
            @(negedge clk);
            if (wb.lsu_ready) done = 1;
            else if (++waited > 50) begin
                n_checks++; n_fail++;
                $display("FAIL lsu_timeout: got no ready expected ready within 50 cycles");
                done = 1;
            end
            @(posedge clk); #1;
        end
        wb.lsu_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic stop_checking();
        @(posedge clk); #3;
        chk_en = 1'b0;
        check("drain", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int start;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd1; wb.alu_data = '0;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd2; wb.lsu_data = '0;
        issue_ld_valid = 1'b0; issue_ld_rd = '0; chk_rs1 = '0; chk_rs2 = '0;

        // Reset state, with both requesters already asking.
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_ready", 64'(wb.alu_ready), 64'(0));
        check("rst_lsu_ready", 64'(wb.lsu_ready), 64'(0));
        check("rst_rf_we",     64'(wb.rf_we),     64'(0));
        check("rst_rf_rd",     64'(wb.rf_rd),     64'(0));
        check("rst_rf_wdata",  64'(wb.rf_wdata),  64'(0));
        check("rst_state",     64'(dbg_state),    64'(ALU_PRI));
        check("rst_starve",    64'(dbg_starve_cnt), 64'(0));
        check("rst_hazard",    64'(hazard),       64'(0));
        wb.alu_valid = 1'b0; wb.lsu_valid = 1'b0;
        res = 1'b1;
        idle(1);
        chk_en = 1'b1;

        // Single ALU write.
        alu_send(5'd5, 32'hDEADBEEF);
        idle(2);

        // Both valid for one cycle, then the LSU alone.
        fork
            alu_send(5'd3, 32'h0000_0333);
            lsu_send(5'd4, 32'h0000_0444);
        join
        idle(2);

        // Continuous contention: LSU must win every 5th cycle.
        lsu_gnt_cyc.delete();
        start = cyc;
        fork
            repeat (20) alu_send(5'($urandom_range(1, 31)), $urandom);
            repeat (4)  lsu_send(5'($urandom_range(1, 31)), $urandom);
        join
        check("starve_count", 64'(lsu_gnt_cyc.size()), 64'(4));
        for (int i = 0; i < lsu_gnt_cyc.size(); i++)
            check("starve_cycle", 64'(lsu_gnt_cyc[i] - start), 64'(4 + 5 * i));
        idle(2);

        // Write to x0 is accepted but not performed.
        lsu_send(5'd0, 32'h0000_1234);
        alu_send(5'd0, 32'h0000_5678);
        idle(2);

        // Pending-load tracking.
        issue_ld_valid = 1'b1; issue_ld_rd = 5'd7;
        idle(1);
        issue_ld_valid = 1'b0; chk_rs1 = 5'd7;
        check("sb_set_rs1", 64'(hazard), 64'(SB_EN));
        chk_rs1 = 5'd0; chk_rs2 = 5'd7; #1;
        check("sb_set_rs2", 64'(hazard), 64'(SB_EN));
        chk_rs1 = 5'd7; chk_rs2 = 5'd0;
        lsu_send(5'd7, 32'h7777_0001);
        check("sb_clear", 64'(hazard), 64'(0));
        fork
            begin issue_ld_valid = 1'b1; issue_ld_rd = 5'd7; idle(1); issue_ld_valid = 1'b0; end
            lsu_send(5'd7, 32'h7777_0002);
        join
        check("sb_set_wins", 64'(hazard), 64'(SB_EN));
        lsu_send(5'd7, 32'h7777_0003);
        check("sb_clear2", 64'(hazard), 64'(0));
        chk_rs1 = 5'd0;
        idle(2);

        // Randomized traffic with independent requesters and load issue.
        fork
            begin
                fork
                    for (int i = 0; i < 60; i++) begin
                        idle($urandom_range(0, 3));
                        alu_send(5'($urandom_range(0, 31)), $urandom);
                    end
                    for (int i = 0; i < 60; i++) begin
                        idle($urandom_range(0, 2));
                        lsu_send(5'($urandom_range(0, 7)), $urandom);
                    end
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    issue_ld_valid = 1'($urandom_range(0, 1));
                    issue_ld_rd    = 5'($urandom_range(0, 7));
                    chk_rs1        = 5'($urandom_range(0, 7));
                    chk_rs2        = 5'($urandom_range(0, 7));
                    idle(1);
                end
                issue_ld_valid = 1'b0;
            end
        join
        idle(3);
        stop_checking();

        // Reset one cycle after a grant drops the registered write.
        @(posedge clk); #1;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd10; wb.alu_data = 32'hCAFE_0001;
        issue_ld_valid = 1'b1; issue_ld_rd = 5'd9; chk_rs1 = 5'd9;
        @(negedge clk);
        check("rst_pre_grant", 64'(wb.alu_ready), 64'(1));
        @(posedge clk); #1;
        wb.alu_valid = 1'b0; issue_ld_valid = 1'b0;
        check("rst_pre_we",     64'(wb.rf_we), 64'(1));
        check("rst_pre_hazard", 64'(hazard),   64'(SB_EN));
        res = 1'b0;
        wb.alu_valid = 1'b1; wb.lsu_valid = 1'b1;
        #1;
        check("rst_async_we",     64'(wb.rf_we),     64'(0));
        check("rst_async_rd",     64'(wb.rf_rd),     64'(0));
        check("rst_async_wdata",  64'(wb.rf_wdata),  64'(0));
        check("rst_async_alu_rdy", 64'(wb.alu_ready), 64'(0));
        check("rst_async_lsu_rdy", 64'(wb.lsu_ready), 64'(0));
        check("rst_async_hazard", 64'(hazard),       64'(0));
        wb.alu_valid = 1'b0; wb.lsu_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        res = 1'b1;
        #1;
        check("post_rst_state",  64'(dbg_state), 64'(ALU_PRI));
        check("post_rst_hazard", 64'(hazard),    64'(0));
        @(posedge clk); #1;
        check("post_rst_we",     64'(wb.rf_we),  64'(0));
        check("post_rst_hazard2", 64'(hazard),   64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
